// File: rtl/muldiv_iterativo_if.sv
// muldiv_iterativo_if: bundles the Execute-stage signals of the iterative
// multiply/divide unit.
//   master : pipeline side, drives the op request and operands, receives results
//   slave  : the muldiv unit
// Request : StartE, ALUControlE, FlushE, SrcAE, SrcBE, SrcCE, SrcDE
// Response: ResultLoE, ResultHiE, DoneE, BusyE, StallMDE
interface muldiv_iterativo_if #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned ALUCONTROL_WIDTH = 5
);
  logic                        StartE;
  logic [ALUCONTROL_WIDTH-1:0] ALUControlE;
  logic                        FlushE;
  logic [WIDTH-1:0]            SrcAE;
  logic [WIDTH-1:0]            SrcBE;
  logic [WIDTH-1:0]            SrcCE;
  logic [WIDTH-1:0]            SrcDE;
  logic [WIDTH-1:0]            ResultLoE;
  logic [WIDTH-1:0]            ResultHiE;
  logic                        DoneE;
  logic                        BusyE;
  logic                        StallMDE;

  modport master (
    output StartE, ALUControlE, FlushE, SrcAE, SrcBE, SrcCE, SrcDE,
    input  ResultLoE, ResultHiE, DoneE, BusyE, StallMDE
  );

  modport slave (
    input  StartE, ALUControlE, FlushE, SrcAE, SrcBE, SrcCE, SrcDE,
    output ResultLoE, ResultHiE, DoneE, BusyE, StallMDE
  );
endinterface

// File: rtl/muldiv_iterativo.sv
// muldiv_iterativo: radix-2 iterative multiply / multiply-accumulate /
// long-multiply / divide unit for the Execute stage. Holds the pipeline via
// StallMDE until the result is ready; DoneE pulses for one cycle with results.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : muldiv_iterativo_if.slave (request, operands, results, status)
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   defined   -> multiplies leave CALC once the remaining multiplier bits are zero
//   undefined -> every non-zero-divisor op runs WIDTH CALC cycles
module muldiv_iterativo #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned ALUCONTROL_WIDTH = 5
) (
  input logic               clk,
  input logic               reset,
  muldiv_iterativo_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [ALUCONTROL_WIDTH-1:0] OP_MUL   = ALUCONTROL_WIDTH'(7);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_MLA   = ALUCONTROL_WIDTH'(8);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_MLS   = ALUCONTROL_WIDTH'(9);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_UMULL = ALUCONTROL_WIDTH'(10);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_UMLAL = ALUCONTROL_WIDTH'(11);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_SMULL = ALUCONTROL_WIDTH'(12);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_SMLAL = ALUCONTROL_WIDTH'(13);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_UDIV  = ALUCONTROL_WIDTH'(14);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_SDIV  = ALUCONTROL_WIDTH'(15);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic op_is_valid(input logic [ALUCONTROL_WIDTH-1:0] op);
    case (op)
      OP_MUL, OP_MLA, OP_MLS, OP_UMULL, OP_UMLAL,
      OP_SMULL, OP_SMLAL, OP_UDIV, OP_SDIV: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(input logic [ALUCONTROL_WIDTH-1:0] op);
    return (op == OP_UDIV) || (op == OP_SDIV);
  endfunction

  function automatic logic op_is_signed(input logic [ALUCONTROL_WIDTH-1:0] op);
    return (op == OP_SMULL) || (op == OP_SMLAL) || (op == OP_SDIV);
  endfunction

  state_t                      state_q;
  logic [CNT_W-1:0]            count_q;
  logic [ALUCONTROL_WIDTH-1:0] op_q;
  logic                        sign_a_q;
  logic                        sign_b_q;
  // Multiply: product accumulator. Divide: {remainder, dividend/quotient}.
  logic [ACC_W-1:0]            acc_q;
  // Multiply: multiplicand shifted left each step. Divide: divisor in low word.
  logic [ACC_W-1:0]            mcand_q;
  // Multiplier magnitude, consumed LSB first.
  logic [WIDTH-1:0]            mplier_q;
  logic [WIDTH-1:0]            src_c_q;
  logic [WIDTH-1:0]            src_d_q;
  logic [WIDTH-1:0]            res_lo_q;
  logic [WIDTH-1:0]            res_hi_q;
  logic                        done_q;
  logic                        busy_q;

  // Request decode and operand magnitudes for the accept cycle.
  logic             in_valid;
  logic             in_div;
  logic             in_signed;
  logic             in_sign_a;
  logic             in_sign_b;
  logic             in_b_zero;
  logic             in_mul_skip;
  logic             start_ok;
  logic [WIDTH-1:0] in_mag_a;
  logic [WIDTH-1:0] in_mag_b;

  always_comb begin
    in_valid  = op_is_valid(bus.ALUControlE);
    in_div    = op_is_div(bus.ALUControlE);
    in_signed = op_is_signed(bus.ALUControlE);
    in_sign_a = in_signed & bus.SrcAE[WIDTH-1];
    in_sign_b = in_signed & bus.SrcBE[WIDTH-1];
    in_mag_a  = in_sign_a ? WIDTH'(0) - bus.SrcAE : bus.SrcAE;
    in_mag_b  = in_sign_b ? WIDTH'(0) - bus.SrcBE : bus.SrcBE;
    in_b_zero = (in_mag_b == '0);
`ifdef MULDIV_EARLY_OUT_EN
    in_mul_skip = in_b_zero;
`else
    in_mul_skip = 1'b0;
`endif
    start_ok  = bus.StartE & in_valid & ~bus.FlushE;
  end

  // One radix-2 iteration of each algorithm.
  logic             cur_div;
  logic [ACC_W-1:0] mul_acc_d;
  logic [ACC_W-1:0] div_acc_d;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic             calc_last;
  logic             mul_early;

  always_comb begin
    cur_div   = op_is_div(op_q);
    mul_acc_d = acc_q + (mplier_q[0] ? mcand_q : ACC_W'(0));
    // Remainder shifted left with the next dividend bit brought in.
    div_trial = acc_q[ACC_W-1:WIDTH-1];
    div_ge    = div_trial >= {1'b0, mcand_q[WIDTH-1:0]};
    div_diff  = WIDTH'(div_trial - {1'b0, mcand_q[WIDTH-1:0]});
    div_acc_d = {(div_ge ? div_diff : div_trial[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
`ifdef MULDIV_EARLY_OUT_EN
    mul_early = ~cur_div & (mplier_q[WIDTH-1:1] == '0);
`else
    mul_early = 1'b0;
`endif
    calc_last = (count_q == CNT_W'(WIDTH - 1)) | mul_early;
  end

  // Sign fix-up and accumulation applied in FIX.
  logic [ACC_W-1:0] prod;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] fix_hi;

  always_comb begin
    prod   = (sign_a_q ^ sign_b_q) ? ACC_W'(0) - acc_q : acc_q;
    quot   = (sign_a_q ^ sign_b_q) ? WIDTH'(0) - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = sign_a_q ? WIDTH'(0) - acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    fix_hi = prod[ACC_W-1:WIDTH];
    case (op_q)
      OP_MLA:             fix_lo = prod[WIDTH-1:0] + src_c_q;
      OP_MLS:             fix_lo = src_c_q - prod[WIDTH-1:0];
      OP_UMLAL, OP_SMLAL: {fix_hi, fix_lo} = prod + {src_d_q, src_c_q};
      OP_UDIV, OP_SDIV: begin
        fix_lo = quot;
        fix_hi = rem;
      end
      default: ;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      src_c_q  <= '0;
      src_d_q  <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            op_q     <= bus.ALUControlE;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            src_c_q  <= bus.SrcCE;
            src_d_q  <= bus.SrcDE;
            mplier_q <= in_mag_b;
            count_q  <= '0;
            busy_q   <= 1'b1;
            if (in_div) begin
              mcand_q <= {WIDTH'(0), in_mag_b};
              // Zero divisor: quotient 0, remainder = dividend, straight to FIX.
              acc_q   <= in_b_zero ? {in_mag_a, WIDTH'(0)} : {WIDTH'(0), in_mag_a};
              state_q <= in_b_zero ? S_FIX : S_CALC;
            end else begin
              mcand_q <= {WIDTH'(0), in_mag_a};
              acc_q   <= '0;
              state_q <= in_mul_skip ? S_FIX : S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.FlushE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            count_q <= count_q + CNT_W'(1);
            if (cur_div) begin
              acc_q <= div_acc_d;
            end else begin
              acc_q    <= mul_acc_d;
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
            end
            if (calc_last) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (bus.FlushE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            res_lo_q <= fix_lo;
            res_hi_q <= fix_hi;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          // StartE is deliberately ignored here; the next op is accepted in IDLE.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ResultLoE = res_lo_q;
  assign bus.ResultHiE = res_hi_q;
  assign bus.DoneE     = done_q;
  assign bus.BusyE     = busy_q;
  // Combinational in IDLE so the requesting instruction never leaves E.
  assign bus.StallMDE  = ((state_q == S_IDLE) & bus.StartE & in_valid)
                       | (state_q == S_CALC) | (state_q == S_FIX);

endmodule

// File: tb/tb_muldiv_iterativo.sv
// tb_muldiv_iterativo: self-checking bench for muldiv_iterativo. Expected
// results and latencies come from a behavioural model, pushed to a scoreboard
// queue at issue and popped when DoneE is seen. Honours MULDIV_EARLY_OUT_EN.
module tb_muldiv_iterativo;

  localparam logic [4:0] OP_MUL   = 5'b00111;
  localparam logic [4:0] OP_MLA   = 5'b01000;
  localparam logic [4:0] OP_MLS   = 5'b01001;
  localparam logic [4:0] OP_UMULL = 5'b01010;
  localparam logic [4:0] OP_UMLAL = 5'b01011;
  localparam logic [4:0] OP_SMULL = 5'b01100;
  localparam logic [4:0] OP_SMLAL = 5'b01101;
  localparam logic [4:0] OP_UDIV  = 5'b01110;
  localparam logic [4:0] OP_SDIV  = 5'b01111;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [7:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  muldiv_iterativo_if #(.WIDTH(32), .ALUCONTROL_WIDTH(5)) bus ();

  muldiv_iterativo #(.WIDTH(32), .ALUCONTROL_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, b, c, d);
    logic [63:0] pu;
    logic [63:0] ps;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    pu = {32'd0, a} * {32'd0, b};
    ps = sa * sb;
    case (op)
      OP_MUL:   return pu;
      OP_MLA:   return {pu[63:32], pu[31:0] + c};
      OP_MLS:   return {pu[63:32], c - pu[31:0]};
      OP_UMULL: return pu;
      OP_UMLAL: return pu + {d, c};
      OP_SMULL: return ps;
      OP_SMLAL: return ps + {d, c};
      OP_UDIV:  return (b == 32'd0) ? {a, 32'd0} : {a % b, a / b};
      OP_SDIV: begin
        if (b == 32'd0) return {a, 32'd0};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default:  return 64'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] b);
    int lat;
    lat = 34;
    if ((op == OP_UDIV || op == OP_SDIV) && b == 32'd0) lat = 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (op != OP_UDIV && op != OP_SDIV) begin
      logic [31:0] bm;
      bm = ((op == OP_SMULL || op == OP_SMLAL) && b[31]) ? -b : b;
      if (bm == 32'd0) lat = 2;
      else for (int i = 0; i < 32; i++) if (bm[i]) lat = i + 3;
    end
`endif
    return lat;
  endfunction

  // Issue one op, follow it to DoneE and check stall/busy, latency and results.
  // With chain set, StartE is left high in the DONE cycle (must be ignored)
  // and the caller issues the next op immediately.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, b, c, d, input bit chain,
                       output logic [31:0] lo, output logic [31:0] hi, output int lat);
    exp_t e;
    logic [63:0] m;
    int cyc;
    bit seen;
    m = model(op, a, b, c, d);
    e.lo = m[31:0];
    e.hi = m[63:32];
    e.lat = 8'(model_lat(op, b));
    sb_q.push_back(e);
    @(negedge clk);
    bus.StartE = 1'b1;
    bus.ALUControlE = op;
    bus.SrcAE = a;
    bus.SrcBE = b;
    bus.SrcCE = c;
    bus.SrcDE = d;
    #1;
    n_cmp++;
    if (bus.StallMDE !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_cycle0 op=%b: got %b want 1", op, bus.StallMDE);
    end
    @(posedge clk);
    #1 bus.StartE = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (bus.DoneE === 1'b1) seen = 1'b1;
      else begin
        n_cmp++;
        if ({bus.StallMDE, bus.BusyE} !== 2'b11) begin
          n_bad++;
          $display("FAIL stall_busy op=%b cycle %0d: got %b%b want 11", op, cyc, bus.StallMDE, bus.BusyE);
        end
        cyc++;
      end
    end
    e = sb_q.pop_front();
    lat = seen ? cyc : -1;
    lo = bus.ResultLoE;
    hi = bus.ResultHiE;
    n_cmp++;
    if (!seen || cyc != int'(e.lat)) begin
      n_bad++;
      $display("FAIL latency op=%b a=%h b=%h: got %0d want %0d", op, a, b, lat, e.lat);
    end
    if (seen) begin
      n_cmp++;
      if (bus.ResultLoE !== e.lo || bus.ResultHiE !== e.hi) begin
        n_bad++;
        $display("FAIL result op=%b a=%h b=%h c=%h d=%h: got %h_%h want %h_%h",
                 op, a, b, c, d, bus.ResultHiE, bus.ResultLoE, e.hi, e.lo);
      end
      n_cmp++;
      if ({bus.StallMDE, bus.BusyE} !== 2'b01) begin
        n_bad++;
        $display("FAIL done_status op=%b: got stall=%b busy=%b want 0 1", op, bus.StallMDE, bus.BusyE);
      end
      last_lo = e.lo;
      last_hi = e.hi;
    end
    if (chain) begin
      bus.StartE = 1'b1;
      #1;
      n_cmp++;
      if (bus.StallMDE !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_in_done: got %b want 0", bus.StallMDE);
      end
    end else begin
      @(negedge clk);
      n_cmp++;
      if (bus.DoneE !== 1'b0 || bus.BusyE !== 1'b0 || bus.ResultLoE !== last_lo || bus.ResultHiE !== last_hi) begin
        n_bad++;
        $display("FAIL after_done: got done=%b busy=%b res=%h_%h want 0 0 %h_%h",
                 bus.DoneE, bus.BusyE, bus.ResultHiE, bus.ResultLoE, last_hi, last_lo);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.DoneE, bus.BusyE, bus.StallMDE} !== 3'b000 || bus.ResultLoE !== 32'd0 || bus.ResultHiE !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: got done=%b busy=%b stall=%b res=%h_%h want all 0",
               bus.DoneE, bus.BusyE, bus.StallMDE, bus.ResultHiE, bus.ResultLoE);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.DoneE, bus.BusyE, bus.StallMDE} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_release: got %b%b%b want 000", bus.DoneE, bus.BusyE, bus.StallMDE);
    end
  endtask

  task automatic test_plan();
    logic [31:0] lo, hi;
    int lat;
    do_op(OP_MUL, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    n_cmp++;
    if (lo !== 32'd42 || hi !== 32'd0) begin
      n_bad++; $display("FAIL mul_7x6: got %h_%h want 00000000_0000002a", hi, lo);
    end
`ifndef MULDIV_EARLY_OUT_EN
    n_cmp++;
    if (lat != 34) begin n_bad++; $display("FAIL mul_latency: got %0d want 34", lat); end
`endif
    do_op(OP_SMULL, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    n_cmp++;
    if (lo !== 32'hFFFFFFF1 || hi !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL smull: got %h_%h want ffffffff_fffffff1", hi, lo);
    end
    do_op(OP_UMLAL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, lo, hi, lat);
    n_cmp++;
    if (lo !== 32'h00000002 || hi !== 32'hFFFFFFFE) begin
      n_bad++; $display("FAIL umlal: got %h_%h want fffffffe_00000002", hi, lo);
    end
    do_op(OP_MLS, 32'd3, 32'd4, 32'd20, 32'd0, 1'b0, lo, hi, lat);
    n_cmp++;
    if (lo !== 32'd8) begin n_bad++; $display("FAIL mls: got %h want 00000008", lo); end
    do_op(OP_SDIV, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    n_cmp++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL sdiv_m7_2: got q=%h r=%h want q=fffffffd r=ffffffff", lo, hi);
    end
    do_op(OP_UDIV, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    n_cmp++;
    if (lo !== 32'd0 || hi !== 32'd5 || lat != 2) begin
      n_bad++; $display("FAIL udiv_by0: got q=%h r=%h lat=%0d want q=0 r=5 lat=2", lo, hi, lat);
    end
    do_op(OP_SDIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    n_cmp++;
    if (lo !== 32'h80000000 || hi !== 32'd0) begin
      n_bad++; $display("FAIL sdiv_ovf: got q=%h r=%h want q=80000000 r=0", lo, hi);
    end
    do_op(OP_SDIV, 32'hFFFFFFF9, 32'd0, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    n_cmp++;
    if (lo !== 32'd0 || hi !== 32'hFFFFFFF9) begin
      n_bad++; $display("FAIL sdiv_by0: got q=%h r=%h want q=0 r=fffffff9", lo, hi);
    end
  endtask

  task automatic test_random();
    logic [4:0] ops [9];
    logic [31:0] a, b, lo, hi;
    int lat;
    ops = '{OP_MUL, OP_MLA, OP_MLS, OP_UMULL, OP_UMLAL, OP_SMULL, OP_SMLAL, OP_UDIV, OP_SDIV};
    for (int i = 0; i < 18; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 1) b = b >> $urandom_range(31, 20);
      if (i % 7 == 3) b = 32'd0;
      do_op(ops[i % 9], a, b, $urandom, $urandom, 1'b0, lo, hi, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] lo, hi;
    int lat;
    do_op(OP_UMULL, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0, 1'b1, lo, hi, lat);
    do_op(OP_UDIV, 32'd1000001, 32'd37, 32'd0, 32'd0, 1'b1, lo, hi, lat);
    do_op(OP_SMLAL, 32'h80000001, 32'h7FFFFFFF, 32'hDEADBEEF, 32'h01234567, 1'b0, lo, hi, lat);
  endtask

  task automatic test_flush();
    logic [31:0] lo, hi;
    int lat;
    // Flush in CALC.
    @(negedge clk);
    bus.StartE = 1'b1; bus.ALUControlE = OP_UDIV; bus.SrcAE = 32'd1000; bus.SrcBE = 32'd7;
    @(posedge clk);
    #1 bus.StartE = 1'b0;
    repeat (10) @(negedge clk);
    bus.FlushE = 1'b1;
    @(posedge clk);
    #1 bus.FlushE = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.DoneE, bus.BusyE, bus.StallMDE} !== 3'b000 || bus.ResultLoE !== last_lo || bus.ResultHiE !== last_hi) begin
      n_bad++;
      $display("FAIL flush_calc: got done=%b busy=%b stall=%b res=%h_%h want 000 %h_%h",
               bus.DoneE, bus.BusyE, bus.StallMDE, bus.ResultHiE, bus.ResultLoE, last_hi, last_lo);
    end
    do_op(OP_MUL, 32'd1234, 32'd5678, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    // Flush in FIX via a zero-divisor op.
    @(negedge clk);
    bus.StartE = 1'b1; bus.ALUControlE = OP_UDIV; bus.SrcAE = 32'd55; bus.SrcBE = 32'd0;
    @(posedge clk);
    #1 bus.StartE = 1'b0;
    @(negedge clk);
    bus.FlushE = 1'b1;
    @(posedge clk);
    #1 bus.FlushE = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.DoneE, bus.BusyE} !== 2'b00 || bus.ResultLoE !== last_lo || bus.ResultHiE !== last_hi) begin
      n_bad++;
      $display("FAIL flush_fix: got done=%b busy=%b res=%h_%h want 00 %h_%h",
               bus.DoneE, bus.BusyE, bus.ResultHiE, bus.ResultLoE, last_hi, last_lo);
    end
    // FlushE with StartE in IDLE must not start.
    bus.StartE = 1'b1; bus.FlushE = 1'b1; bus.ALUControlE = OP_MUL;
    @(posedge clk);
    #1 begin bus.StartE = 1'b0; bus.FlushE = 1'b0; end
    @(negedge clk);
    n_cmp++;
    if (bus.BusyE !== 1'b0) begin n_bad++; $display("FAIL flush_idle: got busy=%b want 0", bus.BusyE); end
  endtask

  task automatic test_invalid();
    logic [4:0] bad [3];
    bad = '{5'b00000, 5'b00110, 5'b10000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.StartE = 1'b1; bus.ALUControlE = bad[i];
      #1;
      n_cmp++;
      if (bus.StallMDE !== 1'b0) begin
        n_bad++; $display("FAIL invalid_stall op=%b: got %b want 0", bad[i], bus.StallMDE);
      end
      @(posedge clk);
      #1 bus.StartE = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.BusyE !== 1'b0) begin
        n_bad++; $display("FAIL invalid_busy op=%b: got %b want 0", bad[i], bus.BusyE);
      end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    bus.StartE = 1'b1; bus.ALUControlE = OP_UMULL; bus.SrcAE = 32'hCAFEF00D; bus.SrcBE = 32'hFFFFFFFF;
    @(posedge clk);
    #1 bus.StartE = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (bus.BusyE !== 1'b1) begin n_bad++; $display("FAIL midop_busy: got %b want 1", bus.BusyE); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.DoneE, bus.BusyE, bus.StallMDE} !== 3'b000 || bus.ResultLoE !== 32'd0 || bus.ResultHiE !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset: got done=%b busy=%b stall=%b res=%h_%h want all 0",
               bus.DoneE, bus.BusyE, bus.StallMDE, bus.ResultHiE, bus.ResultLoE);
    end
    last_lo = '0;
    last_hi = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.DoneE, bus.BusyE, bus.StallMDE} !== 3'b000) begin
      n_bad++; $display("FAIL post_reset_idle: got %b%b%b want 000", bus.DoneE, bus.BusyE, bus.StallMDE);
    end
  endtask

  task automatic test_early_out();
    logic [31:0] lo, hi;
    int lat;
    do_op(OP_MUL, 32'd3, 32'd1, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    n_cmp++;
`ifdef MULDIV_EARLY_OUT_EN
    if (lo !== 32'd3 || lat != 3) begin
      n_bad++; $display("FAIL mul_3x1: got lo=%h lat=%0d want lo=3 lat=3", lo, lat);
    end
`else
    if (lo !== 32'd3 || lat != 34) begin
      n_bad++; $display("FAIL mul_3x1: got lo=%h lat=%0d want lo=3 lat=34", lo, lat);
    end
`endif
    do_op(OP_SMULL, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    do_op(OP_UMULL, 32'd123, 32'd0, 32'd0, 32'd0, 1'b0, lo, hi, lat);
    do_op(OP_SMLAL, 32'd9, 32'hFFFFFFF0, 32'd5, 32'd7, 1'b0, lo, hi, lat);
  endtask

  initial begin
    reset = 1'b0;
    bus.StartE = 1'b0;
    bus.ALUControlE = '0;
    bus.FlushE = 1'b0;
    bus.SrcAE = '0;
    bus.SrcBE = '0;
    bus.SrcCE = '0;
    bus.SrcDE = '0;
    test_reset();
    test_plan();
    test_invalid();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    test_early_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
